// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter.
// Frames are sent back-to-back with no idle gap while bytes remain queued.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx,
  output logic                     busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   CountMax = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic              tx_q, tx_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [7:0]        mem_q [DEPTH];

  logic wr_accept, pop, bit_done;

  assign full  = (count_q == CountMax);
  assign count = count_q;
  assign tx    = tx_q;
  assign busy  = (state_q != StIdle);

  always_comb begin
    wr_accept = wr_en && !full;
    bit_done  = (clk_cnt_q == CntMax);
    pop       = 1'b0;
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
    rd_ptr_d  = rd_ptr_q;

    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (count_q != '0) pop = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_done) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop always starts a new frame with the start bit on the same edge.
    if (pop) begin
      state_d   = StStart;
      tx_d      = 1'b0;
      shift_d   = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
      clk_cnt_d = '0;
    end

    wr_ptr_d = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      clk_cnt_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      clk_cnt_q <= clk_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-position model checked every cycle plus directed literal checks.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEP   = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, tx, busy;
  logic [3:0] count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .count   (count),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: a byte queue plus the position (in cycles) inside the frame on the line.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;

  logic trace [4096];
  int   tcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic model_step();
    int  n;
    bit  acc, pop;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      n   = mq.size();
      acc = wr_en && (n < DEP);
      pop = (n > 0) && (!m_active || m_pos == FRAME - 1);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      if (pop) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (acc) mq.push_back(wr_data);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_tx", tx, exp_tx());
      check("cmp_busy", busy, m_active);
      check("cmp_count", count, mq.size());
      check("cmp_full", full, mq.size() == DEP);
    end
  end

  task automatic tick(input logic r, input logic w, input logic [7:0] d);
    rst     = r;
    wr_en   = w;
    wr_data = d;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
    if (tcnt < 4096) trace[tcnt] = tx;
    tcnt++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || count != 4'd0) && n < 2000) begin
      tick(1'b0, 1'b0, 8'h00);
      n++;
    end
    check(name, n < 2000, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int         s;
    logic [9:0] exp_a5;
    logic [7:0] b;

    // Reset, with a write presented during reset that must be ignored.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h3C);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      check("idle_tx", tx, 1);
    end

    // Single byte 0xA5.
    tick(1'b0, 1'b1, 8'hA5);
    check("a5_latency_tx", tx, 1);
    s = tcnt;
    repeat (41) tick(1'b0, 1'b0, 8'h00);
    exp_a5 = 10'b1101001010;
    for (int j = 0; j < FRAME; j++) check("a5_line", trace[s+j], exp_a5[j/CPB]);
    check("a5_busy_end", busy, 0);
    check("a5_tx_end", tx, 1);

    // Overflow: ten writes, nine accepted.
    s = tcnt + 1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 8'h10 + 8'(i));
      if (i == 8) begin
        check("ovf_full9", full, 1);
        check("ovf_count9", count, 8);
      end
    end
    check("ovf_full10", full, 1);
    check("ovf_count10", count, 8);
    repeat (352) tick(1'b0, 1'b0, 8'h00);
    for (int f = 0; f < 9; f++) begin
      check("ovf_start", trace[s+f*FRAME+1], 0);
      for (int k = 0; k < 8; k++) b[k] = trace[s + f*FRAME + CPB*(k+1) + 1];
      check("ovf_byte", b, 8'h10 + 8'(f));
      check("ovf_stop", trace[s+f*FRAME+9*CPB+1], 1);
    end
    check("ovf_busy_end", busy, 0);
    wait_idle("ovf_drain");

    // Back-to-back 0x00 then 0xFF.
    tick(1'b0, 1'b1, 8'h00);
    s = tcnt;
    tick(1'b0, 1'b1, 8'hFF);
    repeat (81) tick(1'b0, 1'b0, 8'h00);
    check("b2b_last_data", trace[s+35], 0);
    for (int j = 36; j < 40; j++) check("b2b_stop", trace[s+j], 1);
    check("b2b_start2", trace[s+40], 0);
    check("b2b_start2_end", trace[s+43], 0);
    check("b2b_ff_bit0", trace[s+44], 1);
    check("b2b_busy_end", busy, 0);
    wait_idle("b2b_drain");

    // Write while full at the STOP->START pop edge.
    s = tcnt + 1;
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 8'h40 + 8'(i));
    check("wwf_full", full, 1);
    check("wwf_count8", count, 8);
    repeat (32) tick(1'b0, 1'b0, 8'h00);
    check("wwf_pre_tx", tx, 1);
    tick(1'b0, 1'b1, 8'hEE);
    check("wwf_count7", count, 7);
    check("wwf_full_drop", full, 0);
    check("wwf_tx_start", tx, 0);
    check("wwf_busy", busy, 1);
    wait_idle("wwf_drain");

    // Reset in the middle of a frame with three bytes queued.
    tick(1'b0, 1'b1, 8'h55);
    s = tcnt;
    tick(1'b0, 1'b1, 8'h66);
    tick(1'b0, 1'b1, 8'h77);
    tick(1'b0, 1'b1, 8'h88);
    check("mid_count3", count, 3);
    repeat (12) tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    check("mid_tx", tx, 1);
    check("mid_count", count, 0);
    check("mid_busy", busy, 0);
    check("mid_full", full, 0);
    tick(1'b1, 1'b1, 8'h99);
    check("mid_hold_count", count, 0);
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      check("mid_quiet_tx", tx, 1);
    end
    check("mid_quiet_busy", busy, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL provide parameter DEPTH, default 8: FIFO entries, power of two, legal range 2..256.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL provide port wr_en, input, 1 bit: byte-write request from the cpu.
REQ-006 SHALL provide port wr_data, input, 8 bits: byte to queue, sampled when wr_en=1.
REQ-007 SHALL provide port full, output, 1 bit: high when count equals DEPTH.
REQ-008 SHALL provide port count, output, $clog2(DEPTH)+1 bits: number of queued bytes, excluding the byte being shifted out.
REQ-009 SHALL provide port tx, output, 1 bit: UART serial line, idle high, registered.
REQ-010 SHALL provide port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL accept a write at an edge only when wr_en=1 and full=0, where full is the registered pre-edge value.
REQ-012 SHALL drop a write presented while full=1 with no state change, even if a pop occurs at the same edge.
REQ-013 SHALL update count as follows: +1 on write only; -1 on pop only; unchanged on simultaneous write and pop.
REQ-014 SHALL wrap the read and write pointers modulo DEPTH.
REQ-015 SHALL implement states IDLE, START, DATA and STOP.
REQ-016 SHALL, in IDLE with count>0, pop the head byte into the shift register, enter START and drive tx=0 at the same edge.
REQ-017 SHALL hold tx=0 in START for CLKS_PER_BIT cycles, then enter DATA.
REQ-018 SHALL, in DATA, send 8 bits LSB first, each held for CLKS_PER_BIT cycles, using a 3-bit bit index and a cycle counter, then enter STOP.
REQ-019 SHALL hold tx=1 in STOP for CLKS_PER_BIT cycles.
REQ-020 SHALL, at the last STOP cycle, pop and enter START if count>0 (gapless back-to-back), otherwise return to IDLE.
REQ-021 SHALL make one frame exactly 10*CLKS_PER_BIT cycles.
REQ-022 SHALL have latency of one edge: a byte written at edge k into an empty FIFO in IDLE gives tx=0 after edge k+1.
REQ-023 SHALL allow a write and a pop at the same edge, each operating on its own pointer.
REQ-024 SHALL never change tx or the shift register in response to writes during a frame.

Reset
REQ-025 SHALL, with rst=1 at an edge, set state=IDLE, tx=1, busy=0, count=0, full=0, and both pointers and all counters to 0.
REQ-026 SHALL give reset priority over wr_en and over any pop at the same edge.
REQ-027 SHALL, on reset mid-frame, abort the frame (tx=1 after that edge) and discard all queued bytes.
REQ-028 SHALL hold the reset values for every cycle that rst remains high.

Verification (CLKS_PER_BIT=4, DEPTH=8)
REQ-029 SHALL cover reset: rst=1 for 2 cycles -> tx=1, busy=0, count=0, full=0; no tx activity for 20 idle cycles after.
REQ-030 SHALL cover a single byte: write 0xA5 at edge k -> tx=0 during cycles k+1..k+4, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, stop high 4 cycles; busy=0 after edge k+41.
REQ-031 SHALL cover overflow: write 10 bytes on consecutive edges starting from empty -> 9 accepted, full=1 after the 9th, the 10th dropped; 9 gapless frames (360 cycles) carry the first 9 bytes in order.
REQ-032 SHALL cover back-to-back frames: queue 0x00 then 0xFF -> the second start bit begins on the cycle immediately after the 4th stop cycle of the first frame; line high for exactly 4 cycles between frames.
REQ-033 SHALL cover write-while-full with pop: with full=1, assert wr_en at the STOP->START pop edge -> write dropped, count 8->7.
REQ-034 SHALL cover reset mid-frame: rst pulsed at cycle 15 of a frame with 3 bytes queued -> tx=1, count=0, busy=0 after that edge; no further frames.
